// File: rtl/sep_filter2d.sv
// Separable 2D filter: internal kernel line buffer feeding H, V and round/clamp stages,
// with frame-synchronous coefficient shadowing, runtime bypass and per-frame saturation count.
module sep_filter2d #(
    parameter int PIXEL_WIDTH      = 8,
    parameter int KERNEL_SIZE      = 3,
    parameter int COEFF_WIDTH      = 10,
    parameter int COEFF_FRAC_WIDTH = 8,
    parameter int COEFF_SIGNED     = 1,
    parameter int MAX_COLS         = 1288,
    parameter int MAX_COLS_WIDTH   = 11,
    parameter int DTYPE_WIDTH      = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               enable,
    input  logic [KERNEL_SIZE*COEFF_WIDTH-1:0] h_coeffs,
    input  logic [KERNEL_SIZE*COEFF_WIDTH-1:0] v_coeffs,
    input  logic                               dvi,
    input  logic [DTYPE_WIDTH-1:0]             dtypei,
    input  logic [PIXEL_WIDTH-1:0]             datai,
    input  logic [15:0]                        meta_datai,
    output logic                               dvo,
    output logic [DTYPE_WIDTH-1:0]             dtypeo,
    output logic [PIXEL_WIDTH-1:0]             datao,
    output logic [15:0]                        meta_datao,
    output logic [15:0]                        sat_count
);

    // Data type codes; any other code is a meta word.
    localparam logic [DTYPE_WIDTH-1:0] DT_FRAME_START = DTYPE_WIDTH'(1);
    localparam logic [DTYPE_WIDTH-1:0] DT_FRAME_END   = DTYPE_WIDTH'(2);
    localparam logic [DTYPE_WIDTH-1:0] DT_ROW_START   = DTYPE_WIDTH'(3);
    localparam logic [DTYPE_WIDTH-1:0] DT_ROW_END     = DTYPE_WIDTH'(4);
    localparam logic [DTYPE_WIDTH-1:0] DT_PIXEL       = DTYPE_WIDTH'(5);

    localparam int KLOG  = $clog2(KERNEL_SIZE);
    localparam int HW    = PIXEL_WIDTH + COEFF_WIDTH + KLOG + 1;
    localparam int VW    = HW + COEFF_WIDTH + KLOG + 1;
    localparam int SHIFT = 2 * COEFF_FRAC_WIDTH;
    localparam int ROWW  = KLOG + 1;

    localparam logic signed [VW-1:0] ROUND   = VW'(1) << (SHIFT - 1);
    localparam logic signed [VW-1:0] PIX_MAX = VW'((2 ** PIXEL_WIDTH) - 1);

    typedef enum logic {ST_META, ST_IMAGE} state_t;
    state_t state, state_next;

    logic [KERNEL_SIZE*COEFF_WIDTH-1:0] sh_h, sh_v;
    logic                               sh_en;

    logic fs_in, fe_in, is_pix, filt_in, pass_in, kern_in;

    assign fs_in   = dvi && (dtypei == DT_FRAME_START);
    assign fe_in   = dvi && (dtypei == DT_FRAME_END);
    assign is_pix  = (dtypei == DT_ROW_START) || (dtypei == DT_ROW_END) || (dtypei == DT_PIXEL);
    assign filt_in = dvi && (state == ST_IMAGE) && sh_en && !fs_in && !fe_in;
    assign pass_in = dvi && !filt_in;
    // Non-pixel words inside a filtered frame have no window position and are dropped.
    assign kern_in = filt_in && is_pix;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_META;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (fs_in)      state_next = ST_IMAGE;
        else if (fe_in) state_next = ST_META;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_h  <= '0;
            sh_v  <= '0;
            sh_en <= 1'b0;
        end else if (fs_in) begin
            sh_h  <= h_coeffs;
            sh_v  <= v_coeffs;
            sh_en <= enable;
        end
    end

    // ---------------- kernel: line buffers and KxK window ----------------
    logic [PIXEL_WIDTH-1:0]    line_mem [0:KERNEL_SIZE-2][0:MAX_COLS-1];
    logic [PIXEL_WIDTH-1:0]    win      [0:KERNEL_SIZE-1][0:KERNEL_SIZE-1];
    logic [PIXEL_WIDTH-1:0]    col_vec  [0:KERNEL_SIZE-1];
    logic [MAX_COLS_WIDTH-1:0] col_cnt, col_cur;
    logic [ROWW-1:0]           row_cnt;
    logic                      kern_dv;
    logic [DTYPE_WIDTH-1:0]    kern_dt;

    assign col_cur = (dtypei == DT_ROW_START) ? '0 : col_cnt;

    // Row 0 of the window is the oldest line; the live pixel enters the bottom row.
    always_comb begin
        for (int r = 0; r < KERNEL_SIZE - 1; r++) begin
            col_vec[r] = line_mem[KERNEL_SIZE-2-r][col_cur];
        end
        col_vec[KERNEL_SIZE-1] = datai;
    end

    always_ff @(posedge clk) begin
        if (kern_in && (int'(col_cur) < MAX_COLS)) begin
            line_mem[0][col_cur] <= datai;
            for (int i = 1; i < KERNEL_SIZE - 1; i++) begin
                line_mem[i][col_cur] <= line_mem[i-1][col_cur];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_cnt <= '0;
            row_cnt <= '0;
            kern_dv <= 1'b0;
            kern_dt <= '0;
            for (int r = 0; r < KERNEL_SIZE; r++) begin
                for (int c = 0; c < KERNEL_SIZE; c++) begin
                    win[r][c] <= '0;
                end
            end
        end else begin
            kern_dv <= 1'b0;
            if (fs_in) begin
                col_cnt <= '0;
                row_cnt <= '0;
            end else if (kern_in) begin
                for (int r = 0; r < KERNEL_SIZE; r++) begin
                    for (int c = 0; c < KERNEL_SIZE - 1; c++) begin
                        win[r][c] <= win[r][c+1];
                    end
                    win[r][KERNEL_SIZE-1] <= col_vec[r];
                end
                // row_cnt saturates at K-1, so equality means "window rows are all filled".
                kern_dv <= (row_cnt == ROWW'(KERNEL_SIZE - 1)) &&
                           (col_cur >= MAX_COLS_WIDTH'(KERNEL_SIZE - 1));
                if (col_cur == MAX_COLS_WIDTH'(KERNEL_SIZE - 1)) kern_dt <= DT_ROW_START;
                else if (dtypei == DT_ROW_END)                   kern_dt <= DT_ROW_END;
                else                                             kern_dt <= DT_PIXEL;
                if (dtypei == DT_ROW_END) begin
                    col_cnt <= '0;
                    if (row_cnt != ROWW'(KERNEL_SIZE - 1)) row_cnt <= row_cnt + ROWW'(1);
                end else begin
                    col_cnt <= col_cur + MAX_COLS_WIDTH'(1);
                end
            end
        end
    end

    // ---------------- arithmetic helpers ----------------
    function automatic logic signed [COEFF_WIDTH:0] coef_ext(input logic [COEFF_WIDTH-1:0] c);
        if (COEFF_SIGNED != 0) coef_ext = $signed({c[COEFF_WIDTH-1], c});
        else                   coef_ext = $signed({1'b0, c});
    endfunction

    function automatic logic signed [HW-1:0] pix_ext(input logic [PIXEL_WIDTH-1:0] p);
        pix_ext = $signed(HW'(p));
    endfunction

    // ---------------- stage H ----------------
    logic signed [HW-1:0]   h_comb [0:KERNEL_SIZE-1];
    logic signed [HW-1:0]   h_reg  [0:KERNEL_SIZE-1];
    logic                   h_dv;
    logic [DTYPE_WIDTH-1:0] h_dt;

    always_comb begin
        for (int r = 0; r < KERNEL_SIZE; r++) begin
            h_comb[r] = '0;
            for (int c = 0; c < KERNEL_SIZE; c++) begin
                h_comb[r] = h_comb[r] +
                            HW'(coef_ext(sh_h[c*COEFF_WIDTH +: COEFF_WIDTH])) * pix_ext(win[r][c]);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_dv <= 1'b0;
            h_dt <= '0;
            for (int r = 0; r < KERNEL_SIZE; r++) h_reg[r] <= '0;
        end else begin
            h_dv <= kern_dv;
            h_dt <= kern_dt;
            for (int r = 0; r < KERNEL_SIZE; r++) h_reg[r] <= h_comb[r];
        end
    end

    // ---------------- stage V ----------------
    logic signed [VW-1:0]   acc_comb, acc_reg;
    logic                   v_dv;
    logic [DTYPE_WIDTH-1:0] v_dt;

    always_comb begin
        acc_comb = '0;
        for (int r = 0; r < KERNEL_SIZE; r++) begin
            acc_comb = acc_comb +
                       VW'(coef_ext(sh_v[r*COEFF_WIDTH +: COEFF_WIDTH])) * VW'(h_reg[r]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_reg <= '0;
            v_dv    <= 1'b0;
            v_dt    <= '0;
        end else begin
            acc_reg <= acc_comb;
            v_dv    <= h_dv;
            v_dt    <= h_dt;
        end
    end

    // ---------------- stage O: round, clamp, output mux ----------------
    logic signed [VW-1:0]   rnd;
    logic [PIXEL_WIDTH-1:0] pix_out;
    logic                   clamped;
    logic [15:0]            sat_run, sat_run_next;

    always_comb begin
        rnd     = (acc_reg + ROUND) >>> SHIFT;
        pix_out = rnd[PIXEL_WIDTH-1:0];
        clamped = 1'b0;
        if (rnd < 0) begin
            pix_out = '0;
            clamped = 1'b1;
        end else if (rnd > PIX_MAX) begin
            pix_out = '1;
            clamped = 1'b1;
        end
    end

    always_comb begin
        sat_run_next = sat_run;
        if (v_dv && clamped && (sat_run != 16'hFFFF)) sat_run_next = sat_run + 16'd1;
    end

    // A filtered pixel owns the output slot; upstream keeps the frame end at least
    // three idle cycles behind the last pixel so the two never collide.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dvo        <= 1'b0;
            dtypeo     <= '0;
            datao      <= '0;
            meta_datao <= '0;
        end else begin
            meta_datao <= meta_datai;
            if (v_dv) begin
                dvo    <= 1'b1;
                dtypeo <= v_dt;
                datao  <= pix_out;
            end else if (pass_in) begin
                dvo    <= 1'b1;
                dtypeo <= dtypei;
                datao  <= datai;
            end else begin
                dvo    <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sat_run   <= '0;
            sat_count <= '0;
        end else if (fe_in) begin
            sat_count <= sat_run_next;
            sat_run   <= '0;
        end else begin
            sat_run   <= sat_run_next;
        end
    end

endmodule

// File: tb/tb_sep_filter2d.sv
// Bench for sep_filter2d: directed frames, expected words queued at issue time and
// checked by an independent output monitor (data, dtype and arrival cycle).
module tb_sep_filter2d;

    localparam logic [3:0] DT_META = 4'd0;
    localparam logic [3:0] DT_FS   = 4'd1;
    localparam logic [3:0] DT_FE   = 4'd2;
    localparam logic [3:0] DT_RS   = 4'd3;
    localparam logic [3:0] DT_RE   = 4'd4;
    localparam logic [3:0] DT_PX   = 4'd5;

    logic        clk, rst, enable, dvi;
    logic [29:0] h_coeffs, v_coeffs;
    logic [3:0]  dtypei, dtypeo;
    logic [7:0]  datai, datao;
    logic [15:0] meta_datai, meta_datao, sat_count;
    logic        dvo;

    sep_filter2d dut (
        .clk(clk), .reset(rst), .enable(enable),
        .h_coeffs(h_coeffs), .v_coeffs(v_coeffs),
        .dvi(dvi), .dtypei(dtypei), .datai(datai), .meta_datai(meta_datai),
        .dvo(dvo), .dtypeo(dtypeo), .datao(datao), .meta_datao(meta_datao),
        .sat_count(sat_count)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] cyc = 32'd0;
    always @(posedge clk) cyc <= cyc + 32'd1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- scoreboard ----------------
    // entry = {expected arrival cycle, dtype, data}
    logic [43:0] exp_q[$];
    logic [43:0] e;
    logic [15:0] exp_meta;
    int          total = 0;
    int          bad   = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) exp_meta <= 16'd0;
        else     exp_meta <= meta_datai;
    end

    always @(negedge clk) begin
        if (!rst) begin
            total++;
            if (meta_datao !== exp_meta) begin
                bad++;
                $display("FAIL meta_delay: got %h want %h (cycle %0d)", meta_datao, exp_meta, cyc);
            end
            if (dvo) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL out_word: unexpected dt=%0d data=%0d at cycle %0d, want nothing",
                             dtypeo, datao, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (e[43:12] !== cyc || e[11:8] !== dtypeo || e[7:0] !== datao) begin
                        bad++;
                        $display("FAIL out_word: got cyc=%0d dt=%0d data=%0d, want cyc=%0d dt=%0d data=%0d",
                                 cyc, dtypeo, datao, e[43:12], e[11:8], e[7:0]);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    // ---------------- driver ----------------
    logic [7:0] img     [0:7][0:7];
    logic [7:0] exp_img [0:7][0:7];
    int         chg_row = -1;

    task automatic set_coeffs(input int c0, input int c1, input int c2);
        h_coeffs = {10'(c2), 10'(c1), 10'(c0)};
        v_coeffs = {10'(c2), 10'(c1), 10'(c0)};
    endtask

    // lat = 0: no output expected; otherwise the word (edt, ed) is due lat cycles later.
    task automatic send(input logic [3:0] dt, input logic [7:0] d, input int lat,
                        input logic [3:0] edt, input logic [7:0] ed);
        dvi        = 1'b1;
        dtypei     = dt;
        datai      = d;
        meta_datai = 16'($urandom_range(0, 65535));
        if (lat > 0) exp_q.push_back({cyc + 32'(lat), edt, ed});
        @(posedge clk);
        #1;
        dvi = 1'b0;
    endtask

    task automatic idle(input int n);
        dvi = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int w, input int h, input bit filt);
        logic [3:0] dt, kdt;
        send(DT_FS, 8'h5A, 1, DT_FS, 8'h5A);
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                if (chg_row == r && c == 0) begin
                    set_coeffs(85, 86, 85);
                    enable = 1'b0;
                end
                if (!filt && r == 1 && c == 0) send(DT_META, 8'hC3, 1, DT_META, 8'hC3);
                dt  = (c == 0) ? DT_RS : (c == w - 1) ? DT_RE : DT_PX;
                kdt = (c == 2) ? DT_RS : (c == w - 1) ? DT_RE : DT_PX;
                if (!filt)                 send(dt, img[r][c], 1, dt, img[r][c]);
                else if (r >= 2 && c >= 2) send(dt, img[r][c], 4, kdt, exp_img[r-1][c-1]);
                else                       send(dt, img[r][c], 0, 4'd0, 8'd0);
            end
        end
        idle(6);
        send(DT_FE, 8'hA5, 1, DT_FE, 8'hA5);
        idle(3);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        rst = 1'b1; enable = 1'b0; dvi = 1'b0; dtypei = 4'd0; datai = 8'd0; meta_datai = 16'd0;
        set_coeffs(0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_dvo", 32'(dvo), 0);
        check("reset_dtypeo", 32'(dtypeo), 0);
        check("reset_datao", 32'(datao), 0);
        check("reset_meta", 32'(meta_datao), 0);
        check("reset_sat", 32'(sat_count), 0);
        rst = 1'b0;
        idle(1);

        // meta words before any frame pass through
        send(DT_META, 8'h11, 1, DT_META, 8'h11);
        send(DT_PX,   8'h22, 1, DT_PX,   8'h22);
        send(DT_META, 8'h33, 1, DT_META, 8'h33);
        idle(2);

        // identity on an 8x6 ramp: interior pixels come back unchanged
        set_coeffs(0, 256, 0);
        enable = 1'b1;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                img[r][c]     = 8'(r * 30 + c * 7 + 3);
                exp_img[r][c] = 8'(r * 30 + c * 7 + 3);
            end
        send_frame(8, 6, 1);
        check("sat_identity", 32'(sat_count), 0);

        // box blur on a flat field of 120
        set_coeffs(85, 86, 85);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                img[r][c]     = 8'd120;
                exp_img[r][c] = 8'd120;
            end
        send_frame(5, 4, 1);
        check("sat_blur", 32'(sat_count), 0);

        // identity frame with a mid-frame switch to blur and disable at row 3
        set_coeffs(0, 256, 0);
        enable  = 1'b1;
        chg_row = 3;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                img[r][c]     = 8'((r * 53 + c * c * 19) % 251);
                exp_img[r][c] = 8'((r * 53 + c * c * 19) % 251);
            end
        send_frame(8, 6, 1);
        chg_row = -1;
        check("sat_midframe", 32'(sat_count), 0);

        // next frame picks up blur: 3x3 spike of 255 -> round(86*86*255/65536) = 29
        enable = 1'b1;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) img[r][c] = 8'd0;
        img[1][1]     = 8'd255;
        exp_img[1][1] = 8'd29;
        send_frame(3, 3, 1);
        check("sat_spike_blur", 32'(sat_count), 0);

        // bypass: every word, borders and meta included, 1 cycle late
        enable = 1'b0;
        set_coeffs(0, 256, 0);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 5; c++) img[r][c] = 8'($urandom_range(0, 255));
        send_frame(5, 4, 0);
        check("sat_bypass", 32'(sat_count), 0);

        // saturation with {-128,511,-128}: spike, mixed and inverse windows all clamp
        enable = 1'b1;
        set_coeffs(-128, 511, -128);
        for (int c = 0; c < 6; c++) begin
            img[0][c] = (c >= 3) ? 8'd255 : 8'd0;
            img[2][c] = (c >= 3) ? 8'd255 : 8'd0;
            img[1][c] = (c == 1 || c == 3 || c == 5) ? 8'd255 : 8'd0;
        end
        exp_img[1][1] = 8'd255;
        exp_img[1][2] = 8'd0;
        exp_img[1][3] = 8'd255;
        exp_img[1][4] = 8'd0;
        send_frame(6, 3, 1);
        check("sat_clamped", 32'(sat_count), 4);
        send(DT_META, 8'h44, 1, DT_META, 8'h44);
        idle(4);
        check("sat_hold", 32'(sat_count), 4);

        // asynchronous reset in the middle of row 2 of a filtered frame
        set_coeffs(0, 256, 0);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                img[r][c]     = 8'(r * 30 + c * 7 + 3);
                exp_img[r][c] = 8'(r * 30 + c * 7 + 3);
            end
        send(DT_FS, 8'h5A, 1, DT_FS, 8'h5A);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < ((r == 2) ? 5 : 8); c++) begin
                if (r >= 2 && c >= 2)
                    send((c == 0) ? DT_RS : DT_PX, img[r][c], 4,
                         (c == 2) ? DT_RS : DT_PX, exp_img[r-1][c-1]);
                else
                    send((c == 0) ? DT_RS : (c == 7) ? DT_RE : DT_PX, img[r][c], 0, 4'd0, 8'd0);
            end
        #3;
        rst = 1'b1;
        #1;
        check("midreset_dvo", 32'(dvo), 0);
        check("midreset_dtypeo", 32'(dtypeo), 0);
        check("midreset_datao", 32'(datao), 0);
        check("midreset_meta", 32'(meta_datao), 0);
        check("midreset_sat", 32'(sat_count), 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // back in META: pixel-typed and meta words pass straight through
        send(DT_PX,   8'h77, 1, DT_PX,   8'h77);
        send(DT_META, 8'h88, 1, DT_META, 8'h88);
        idle(2);

        // recovery frame: 3x3 identity returns the centre pixel
        enable = 1'b1;
        send_frame(3, 3, 1);
        check("sat_recover", 32'(sat_count), 0);

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
